pkt_proc: RTL and testbench
===========================

// Module: pkt_proc
// PURPOSE
// Reconfigurable packet-processing core. Walks a chain of protocol headers in packet memory using a
// runtime-programmed parse graph, then extracts a match key from one selected header. It selects a hit
// or miss action address and writes that address back to memory. Sits between the control plane
// (*_mod_* config ports) and the shared memory adapter (mem -> sram).
// PARAMETERS
// NEXT_TABLE_SIZE  2   next-header entries per header; entry = {tag[31:16], next_hdr_id[15:0]}
// HDR_NUM          16  header slots, indexed by 4-bit hdr_id
// RESULT_ADDR      0   byte address receiving the 32-bit selected action address
// MAX_HDRS         8   header limit; used only with PKT_PROC_LOOP_GUARD_EN
// PORTS
// clk                          in   1     single clock, rising edge
// rst                          in   1     synchronous, active-high reset
// start_i                      in   1     level request to process the packet
// pkt_addr_i                   in   32    byte address of first header
// ready_o                      out  1     processing finished; held while start_i stays high
// hit_o / action_addr_o        out  1/32  match result / selected action address
// mem_ce_o, mem_we_o           out  1,1   memory request strobe, write enable
// mem_addr_o                   out  32    byte address
// mem_width_o                  out  4     access size in bytes, 1..4
// mem_data_o / mem_data_i      out/in 32  write data / read data, right-aligned
// proc_mod_start_i             in   1     write hit/miss action addresses
// proc_mod_hit_action_addr_i   in   32    action address used on a match hit
// proc_mod_miss_action_addr_i  in   32    action address used on a match miss
// ps_mod_start_i               in   1     write parser entry ps_mod_hdr_id_i[3:0]
// ps_mod_hdr_len_i             in   32    header length in bytes
// ps_mod_next_tag_start_i      in   32    tag byte offset within header
// ps_mod_next_tag_len_i        in   32    tag length in bytes
// ps_mod_next_table_i          in   32x[NEXT_TABLE_SIZE]  next-header table
// mt_mod_start_i               in   1     write matcher config
// mt_mod_match_hdr_id_i        in   4     header the key is taken from
// mt_mod_match_key_off_i       in   6     key byte offset within that header
// mt_mod_match_key_len_i       in   6     key length in bytes
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE; all parser, matcher and proc config valid bits cleared.
// - Config writes commit on the clock edge with *_start_i=1. They are ignored unless FSM is IDLE or DONE.
//   A ps write sets valid[hdr_id]. Simultaneous ps/mt/proc writes are all accepted.
// - Memory read: one cycle with ce=1, we=0, addr, width; mem_data_o=0. Data is sampled the next cycle
//   (1-cycle sram latency), big-endian, zero-extended. Write: ce=1, we=1, width=4 for one cycle.
//   ce=0 at all other times.
// - FSM: IDLE -(start_i)-> HDR. Init: cur_id=0, cur_off=pkt_addr_i, parsed[] cleared.
//   HDR: if !valid[cur_id], go MATCH. Otherwise record base[cur_id]=cur_off and set parsed[cur_id].
//     If tag_len is 0, go MATCH; else go TAG_RD.
//   TAG_RD reads from cur_off+tag_start, len=min(tag_len,4). TAG_WT: tag = data[15:0].
//     Scan the table from index 0. 32'hFFFF_FFFF (NO_NEXT_HEADER) is skipped.
//     On the first entry whose tag field equals tag: cur_id=next_id[3:0], cur_off+=hdr_len, go HDR.
//     If nothing matches, go MATCH.
//   MATCH: if mt config is invalid, or hdr not parsed, or key_len=0: miss, go WB.
//     Otherwise go KEY_RD: read base+key_off, len=min(key_len,4). KEY_WT: hit, go WB.
//   WB: action = hit ? hit_addr : miss_addr. Drive hit_o and action_addr_o, write action to RESULT_ADDR, go DONE.
//   DONE: ready_o=1 until start_i=0, then go IDLE with ready_o=0. Results hold until the next start.
// - Offset arithmetic is 32-bit with wrap-around. Latency = 2 + 3*(headers w/ tag) + 3 (key) + 1 cycles.
// - rst asserted mid-operation aborts: the FSM returns to IDLE and no writeback occurs.
// CONFIGURATION
// PKT_PROC_LOOP_GUARD_EN defined: after MAX_HDRS headers, HDR goes straight to MATCH, bounding cyclic graphs.
// Undefined: parsing continues until a header has no matching next entry.
// TESTING
// 1 Eth(id0,len14,tag@12/2,{0x0800->1}) + IP(id1,len20,tag@9/1,none), mt(1,off16,len4),
//   hit=64, miss=0, pkt@4 holding 0x0800 at 16 -> ready_o=1, hit_o=1, key read @34 len4, mem[0]=64.
// 2 Same config, packet EtherType 0x86DD -> IP not parsed, hit_o=0, mem[0]=0, no key read.
// 3 start_i held high -> ready_o stays 1, single writeback. Drop start_i -> ready_o=0 next cycle.
// 4 rst pulsed during TAG_WT -> all outputs 0, no write to RESULT_ADDR, re-run from scratch works.
// 5 ps_mod write issued while busy -> ignored; the current and next packet use the old entry.
// 6 Loop guard on: hdr0 points to itself (tag matches) -> stops after 8 headers, completes with a miss.

Source files
------------

// File: rtl/pkt_proc_if.sv
// Request/result handshake and memory-adapter bus of the packet processor.
// The slave side is the processor, the master side is requester plus sram.
interface pkt_proc_if;
    logic        start_i;
    logic [31:0] pkt_addr_i;
    logic        ready_o;
    logic        hit_o;
    logic [31:0] action_addr_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_width_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    modport slave (
        input  start_i, pkt_addr_i, mem_data_i,
        output ready_o, hit_o, action_addr_o,
        output mem_ce_o, mem_we_o, mem_addr_o,
        output mem_width_o, mem_data_o
    );

    modport master (
        output start_i, pkt_addr_i, mem_data_i,
        input  ready_o, hit_o, action_addr_o,
        input  mem_ce_o, mem_we_o, mem_addr_o,
        input  mem_width_o, mem_data_o
    );
endinterface

// File: rtl/pkt_proc.sv
// pkt_proc: walks a programmable header chain, reads a match key, writes back the action.
// Define PKT_PROC_LOOP_GUARD_EN to stop the walk after MAX_HDRS headers.
module pkt_proc #(
    parameter int          NEXT_TABLE_SIZE = 2,
    parameter int          HDR_NUM         = 16,
    parameter logic [31:0] RESULT_ADDR     = 32'd0,
    parameter int          MAX_HDRS        = 8
) (
    input  logic        clk,
    input  logic        rst,
    pkt_proc_if.slave   io,
    input  logic        proc_mod_start_i,
    input  logic [31:0] proc_mod_hit_action_addr_i,
    input  logic [31:0] proc_mod_miss_action_addr_i,
    input  logic        ps_mod_start_i,
    input  logic [3:0]  ps_mod_hdr_id_i,
    input  logic [31:0] ps_mod_hdr_len_i,
    input  logic [31:0] ps_mod_next_tag_start_i,
    input  logic [31:0] ps_mod_next_tag_len_i,
    input  logic [NEXT_TABLE_SIZE-1:0][31:0] ps_mod_next_table_i,
    input  logic        mt_mod_start_i,
    input  logic [3:0]  mt_mod_match_hdr_id_i,
    input  logic [5:0]  mt_mod_match_key_off_i,
    input  logic [5:0]  mt_mod_match_key_len_i
);

`ifdef PKT_PROC_LOOP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, HDR, TAG_RD, TAG_WT, MATCH,
        KEY_RD, KEY_WT, WB, DONE
    } state_t;

    state_t state, state_nxt;

    logic [HDR_NUM-1:0] ps_valid;
    logic [HDR_NUM-1:0] parsed;
    logic [31:0] hdr_len   [HDR_NUM];
    logic [31:0] tag_start [HDR_NUM];
    logic [31:0] tag_len   [HDR_NUM];
    logic        nt_used   [HDR_NUM][NEXT_TABLE_SIZE];
    logic [15:0] nt_tag    [HDR_NUM][NEXT_TABLE_SIZE];
    logic [3:0]  nt_id     [HDR_NUM][NEXT_TABLE_SIZE];
    logic [31:0] base      [HDR_NUM];

    logic        mt_valid;
    logic [3:0]  mt_hdr;
    logic [5:0]  mt_off;
    logic [5:0]  mt_len;
    logic        proc_valid;
    logic [31:0] hit_addr;
    logic [31:0] miss_addr;

    logic [3:0]  cur_id;
    logic [31:0] cur_off;
    logic [31:0] hdr_cnt;
    logic        hit;

    logic        cfg_ok;
    logic        hdr_limit;
    logic        hdr_take;
    logic        key_ok;
    logic [15:0] tag;
    logic        found;
    logic [3:0]  found_id;
    logic [3:0]  tag_w;
    logic [3:0]  key_w;
    logic [31:0] action;

    // Shared decode: config gate, next-header scan, access widths, action select.
    always_comb begin
        cfg_ok    = (state == IDLE) || (state == DONE);
        hdr_limit = GUARD && (hdr_cnt == 32'(MAX_HDRS));
        hdr_take  = ps_valid[cur_id] && !hdr_limit;
        key_ok    = mt_valid && parsed[mt_hdr] && (mt_len != 6'd0);
        tag       = io.mem_data_i[15:0];
        found     = 1'b0;
        found_id  = '0;
        for (int i = NEXT_TABLE_SIZE - 1; i >= 0; i--) begin
            if (nt_used[cur_id][i] && nt_tag[cur_id][i] == tag) begin
                found    = 1'b1;
                found_id = nt_id[cur_id][i];
            end
        end
        tag_w  = (tag_len[cur_id] > 32'd4) ? 4'd4 : tag_len[cur_id][3:0];
        key_w  = (mt_len > 6'd4) ? 4'd4 : mt_len[3:0];
        action = proc_valid ? (hit ? hit_addr : miss_addr) : 32'd0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus memory strobes and ready flag.
    always_comb begin
        state_nxt      = state;
        io.mem_ce_o    = 1'b0;
        io.mem_we_o    = 1'b0;
        io.mem_addr_o  = 32'd0;
        io.mem_width_o = 4'd0;
        io.mem_data_o  = 32'd0;
        io.ready_o     = 1'b0;
        unique case (state)
            IDLE: begin
                if (io.start_i) state_nxt = HDR;
            end
            HDR: begin
                if (!hdr_take)                   state_nxt = MATCH;
                else if (tag_len[cur_id] == '0) state_nxt = MATCH;
                else                             state_nxt = TAG_RD;
            end
            TAG_RD: begin
                io.mem_ce_o    = 1'b1;
                io.mem_addr_o  = cur_off + tag_start[cur_id];
                io.mem_width_o = tag_w;
                state_nxt      = TAG_WT;
            end
            TAG_WT: begin
                state_nxt = found ? HDR : MATCH;
            end
            MATCH: begin
                state_nxt = key_ok ? KEY_RD : WB;
            end
            KEY_RD: begin
                io.mem_ce_o    = 1'b1;
                io.mem_addr_o  = base[mt_hdr] + {26'd0, mt_off};
                io.mem_width_o = key_w;
                state_nxt      = KEY_WT;
            end
            KEY_WT: begin
                state_nxt = WB;
            end
            WB: begin
                io.mem_ce_o    = 1'b1;
                io.mem_we_o    = 1'b1;
                io.mem_addr_o  = RESULT_ADDR;
                io.mem_width_o = 4'd4;
                io.mem_data_o  = action;
                state_nxt      = DONE;
            end
            DONE: begin
                io.ready_o = 1'b1;
                if (!io.start_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Walk cursor, parsed set, match flag and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id           <= '0;
            cur_off          <= '0;
            parsed           <= '0;
            hdr_cnt          <= '0;
            hit              <= 1'b0;
            io.hit_o         <= 1'b0;
            io.action_addr_o <= '0;
        end else begin
            case (state)
                IDLE: if (io.start_i) begin
                    cur_id           <= '0;
                    cur_off          <= io.pkt_addr_i;
                    parsed           <= '0;
                    hdr_cnt          <= '0;
                    hit              <= 1'b0;
                    io.hit_o         <= 1'b0;
                    io.action_addr_o <= '0;
                end
                HDR: if (hdr_take) begin
                    parsed[cur_id] <= 1'b1;
                    hdr_cnt        <= hdr_cnt + 32'd1;
                end
                TAG_WT: if (found) begin
                    cur_id  <= found_id;
                    cur_off <= cur_off + hdr_len[cur_id];
                end
                MATCH:  hit <= 1'b0;
                KEY_WT: hit <= 1'b1;
                WB: begin
                    io.hit_o         <= hit;
                    io.action_addr_o <= action;
                end
                default: ;
            endcase
        end
    end

    // Header base offsets; only read back for headers marked parsed.
    always_ff @(posedge clk) begin
        if (!rst && state == HDR && hdr_take) base[cur_id] <= cur_off;
    end

    // Config valid bits, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_valid   <= '0;
            mt_valid   <= 1'b0;
            proc_valid <= 1'b0;
        end else if (cfg_ok) begin
            if (ps_mod_start_i)   ps_valid[ps_mod_hdr_id_i] <= 1'b1;
            if (mt_mod_start_i)   mt_valid <= 1'b1;
            if (proc_mod_start_i) proc_valid <= 1'b1;
        end
    end

    // Config payloads; NO_NEXT_HEADER entries are folded into a used flag.
    always_ff @(posedge clk) begin
        if (!rst && cfg_ok && ps_mod_start_i) begin
            hdr_len[ps_mod_hdr_id_i]   <= ps_mod_hdr_len_i;
            tag_start[ps_mod_hdr_id_i] <= ps_mod_next_tag_start_i;
            tag_len[ps_mod_hdr_id_i]   <= ps_mod_next_tag_len_i;
            for (int i = 0; i < NEXT_TABLE_SIZE; i++) begin
                nt_used[ps_mod_hdr_id_i][i] <= ~&ps_mod_next_table_i[i];
                nt_tag[ps_mod_hdr_id_i][i]  <= ps_mod_next_table_i[i][31:16];
                nt_id[ps_mod_hdr_id_i][i]   <= ps_mod_next_table_i[i][3:0];
            end
        end
        if (!rst && cfg_ok && mt_mod_start_i) begin
            mt_hdr <= mt_mod_match_hdr_id_i;
            mt_off <= mt_mod_match_key_off_i;
            mt_len <= mt_mod_match_key_len_i;
        end
        if (!rst && cfg_ok && proc_mod_start_i) begin
            hit_addr  <= proc_mod_hit_action_addr_i;
            miss_addr <= proc_mod_miss_action_addr_i;
        end
    end

endmodule

// File: tb/tb_pkt_proc.sv
// Bench for pkt_proc: byte-array sram model plus read/write scoreboards.
// Loop-guard scenario runs only when PKT_PROC_LOOP_GUARD_EN is defined.
module tb_pkt_proc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_proc_if io();

    logic        proc_mod_start_i;
    logic [31:0] proc_mod_hit_action_addr_i;
    logic [31:0] proc_mod_miss_action_addr_i;
    logic        ps_mod_start_i;
    logic [3:0]  ps_mod_hdr_id_i;
    logic [31:0] ps_mod_hdr_len_i;
    logic [31:0] ps_mod_next_tag_start_i;
    logic [31:0] ps_mod_next_tag_len_i;
    logic [1:0][31:0] ps_mod_next_table_i;
    logic        mt_mod_start_i;
    logic [3:0]  mt_mod_match_hdr_id_i;
    logic [5:0]  mt_mod_match_key_off_i;
    logic [5:0]  mt_mod_match_key_len_i;

    pkt_proc dut (
        .clk                         (clk),
        .rst                         (rst),
        .io                          (io),
        .proc_mod_start_i            (proc_mod_start_i),
        .proc_mod_hit_action_addr_i  (proc_mod_hit_action_addr_i),
        .proc_mod_miss_action_addr_i (proc_mod_miss_action_addr_i),
        .ps_mod_start_i              (ps_mod_start_i),
        .ps_mod_hdr_id_i             (ps_mod_hdr_id_i),
        .ps_mod_hdr_len_i            (ps_mod_hdr_len_i),
        .ps_mod_next_tag_start_i     (ps_mod_next_tag_start_i),
        .ps_mod_next_tag_len_i       (ps_mod_next_tag_len_i),
        .ps_mod_next_table_i         (ps_mod_next_table_i),
        .mt_mod_start_i              (mt_mod_start_i),
        .mt_mod_match_hdr_id_i       (mt_mod_match_hdr_id_i),
        .mt_mod_match_key_off_i      (mt_mod_match_key_off_i),
        .mt_mod_match_key_len_i      (mt_mod_match_key_len_i)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [64];
    logic [63:0] rd_q [$];
    logic [31:0] wr_q [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a,
                                            input logic [3:0] w);
        logic [31:0] d;
        d = 32'd0;
        for (int k = 0; k < 4; k++)
            if (k < int'(w)) d = {d[23:0], mem[(a + 32'(k)) & 32'd63]};
        return d;
    endfunction

    function automatic logic [31:0] result_word();
        return {mem[0], mem[1], mem[2], mem[3]};
    endfunction

    // sram model: one-cycle read latency, big-endian 4-byte writes
    always @(posedge clk) begin
        if (io.mem_ce_o && !io.mem_we_o)
            io.mem_data_i <= rd_word(io.mem_addr_o, io.mem_width_o);
        if (io.mem_ce_o && io.mem_we_o)
            for (int k = 0; k < 4; k++)
                mem[(io.mem_addr_o + 32'(k)) & 32'd63] <= io.mem_data_o[31-8*k -: 8];
    end

    // bus monitor: pop scoreboard entries as the DUT issues accesses
    always @(negedge clk) begin
        if (!rst && io.mem_ce_o) begin
            if (!io.mem_we_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_q.size()), 64'd1);
                else chk("rd_access", {28'd0, io.mem_width_o, io.mem_addr_o},
                         rd_q.pop_front());
            end else begin
                if (wr_q.size() == 0) chk("wr_unexpected", 64'(wr_q.size()), 64'd1);
                else begin
                    chk("wr_addr", 64'(io.mem_addr_o), 64'd0);
                    chk("wr_width", 64'(io.mem_width_o), 64'd4);
                    chk("wr_data", 64'(io.mem_data_o), 64'(wr_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [63:0] rd(input logic [3:0] w, input logic [31:0] a);
        return {28'd0, w, a};
    endfunction

    task automatic ps_write(input logic [3:0] id, input logic [31:0] len,
                            input logic [31:0] ts, input logic [31:0] tl,
                            input logic [31:0] t0, input logic [31:0] t1);
        ps_mod_hdr_id_i         = id;
        ps_mod_hdr_len_i        = len;
        ps_mod_next_tag_start_i = ts;
        ps_mod_next_tag_len_i   = tl;
        ps_mod_next_table_i     = {t1, t0};
        ps_mod_start_i          = 1'b1;
        @(negedge clk);
        ps_mod_start_i          = 1'b0;
    endtask

    task automatic mt_write(input logic [3:0] id, input logic [5:0] off,
                            input logic [5:0] len);
        mt_mod_match_hdr_id_i  = id;
        mt_mod_match_key_off_i = off;
        mt_mod_match_key_len_i = len;
        mt_mod_start_i         = 1'b1;
        @(negedge clk);
        mt_mod_start_i         = 1'b0;
    endtask

    task automatic proc_write(input logic [31:0] h, input logic [31:0] m);
        proc_mod_hit_action_addr_i  = h;
        proc_mod_miss_action_addr_i = m;
        proc_mod_start_i            = 1'b1;
        @(negedge clk);
        proc_mod_start_i            = 1'b0;
    endtask

    task automatic cfg_std();
        ps_write(4'd0, 32'd14, 32'd12, 32'd2, 32'h0800_0001, 32'hFFFF_FFFF);
        ps_write(4'd1, 32'd20, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mt_write(4'd1, 6'd16, 6'd4);
        proc_write(32'd64, 32'd0);
    endtask

    task automatic set_etype(input logic [15:0] t);
        mem[16] = t[15:8];
        mem[17] = t[7:0];
    endtask

    task automatic run_pkt(input string name, input logic exp_hit,
                           input logic [31:0] exp_act, input bit hold,
                           input bit poke);
        int n;
        wr_q.push_back(exp_act);
        io.pkt_addr_i = 32'd4;
        io.start_i    = 1'b1;
        n = 0;
        while (!io.ready_o && n < 200) begin
            @(negedge clk);
            n++;
            if (poke && n == 3) begin
                ps_mod_hdr_id_i         = 4'd0;
                ps_mod_hdr_len_i        = 32'd14;
                ps_mod_next_tag_start_i = 32'd12;
                ps_mod_next_tag_len_i   = 32'd2;
                ps_mod_next_table_i     = {32'hFFFF_FFFF, 32'h86DD_0001};
                ps_mod_start_i          = 1'b1;
            end else begin
                ps_mod_start_i = 1'b0;
            end
        end
        ps_mod_start_i = 1'b0;
        chk({name, "_ready"}, 64'(io.ready_o), 64'd1);
        chk({name, "_hit"}, 64'(io.hit_o), 64'(exp_hit));
        chk({name, "_action"}, 64'(io.action_addr_o), 64'(exp_act));
        chk({name, "_result_mem"}, 64'(result_word()), 64'(exp_act));
        if (hold) begin
            repeat (6) @(negedge clk);
            chk({name, "_ready_held"}, 64'(io.ready_o), 64'd1);
        end
        io.start_i = 1'b0;
        @(negedge clk);
        chk({name, "_ready_drop"}, 64'(io.ready_o), 64'd0);
        chk({name, "_hit_kept"}, 64'(io.hit_o), 64'(exp_hit));
        chk({name, "_rd_left"}, 64'(rd_q.size()), 64'd0);
        chk({name, "_wr_left"}, 64'(wr_q.size()), 64'd0);
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic push_hit_reads();
        rd_q.push_back(rd(4'd2, 32'd16));
        rd_q.push_back(rd(4'd1, 32'd27));
        rd_q.push_back(rd(4'd4, 32'd34));
    endtask

    initial begin
        rst              = 1'b1;
        io.start_i       = 1'b0;
        io.pkt_addr_i    = 32'd0;
        proc_mod_start_i = 1'b0;
        ps_mod_start_i   = 1'b0;
        mt_mod_start_i   = 1'b0;
        proc_mod_hit_action_addr_i  = '0;
        proc_mod_miss_action_addr_i = '0;
        ps_mod_hdr_id_i         = '0;
        ps_mod_hdr_len_i        = '0;
        ps_mod_next_tag_start_i = '0;
        ps_mod_next_tag_len_i   = '0;
        ps_mod_next_table_i     = '0;
        mt_mod_match_hdr_id_i   = '0;
        mt_mod_match_key_off_i  = '0;
        mt_mod_match_key_len_i  = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(io.ready_o), 64'd0);
        chk("rst_hit", 64'(io.hit_o), 64'd0);
        chk("rst_action", 64'(io.action_addr_o), 64'd0);
        chk("rst_ce", 64'(io.mem_ce_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        cfg_std();

        set_etype(16'h0800);
        push_hit_reads();
        run_pkt("eth_ip_hit", 1'b1, 32'd64, 1'b0, 1'b0);

        set_etype(16'h86DD);
        rd_q.push_back(rd(4'd2, 32'd16));
        run_pkt("ipv6_miss", 1'b0, 32'd0, 1'b0, 1'b0);

        set_etype(16'hFFFF);
        rd_q.push_back(rd(4'd2, 32'd16));
        run_pkt("tag_ffff_miss", 1'b0, 32'd0, 1'b0, 1'b0);

        set_etype(16'h0800);
        push_hit_reads();
        run_pkt("start_held", 1'b1, 32'd64, 1'b1, 1'b0);

        push_hit_reads();
        run_pkt("busy_cfg", 1'b1, 32'd64, 1'b0, 1'b1);
        push_hit_reads();
        run_pkt("after_busy_cfg", 1'b1, 32'd64, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) mem[i] = 8'hA5;
        rd_q.push_back(rd(4'd2, 32'd16));
        io.pkt_addr_i = 32'd4;
        io.start_i    = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        io.start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_ready", 64'(io.ready_o), 64'd0);
        chk("abort_hit", 64'(io.hit_o), 64'd0);
        chk("abort_action", 64'(io.action_addr_o), 64'd0);
        chk("abort_ce", 64'(io.mem_ce_o), 64'd0);
        chk("abort_rd_left", 64'(rd_q.size()), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_wb", 64'(result_word()), 64'hA5A5_A5A5);
        rd_q.delete();
        cfg_std();
        push_hit_reads();
        run_pkt("rerun_hit", 1'b1, 32'd64, 1'b0, 1'b0);

        mt_write(4'd1, 6'd16, 6'd0);
        rd_q.push_back(rd(4'd2, 32'd16));
        rd_q.push_back(rd(4'd1, 32'd27));
        run_pkt("keylen0_miss", 1'b0, 32'd0, 1'b0, 1'b0);

`ifdef PKT_PROC_LOOP_GUARD_EN
        ps_write(4'd0, 32'd2, 32'd0, 32'd2, 32'hABCD_0000, 32'hFFFF_FFFF);
        mt_write(4'd5, 6'd0, 6'd4);
        proc_write(32'd64, 32'h99);
        for (int k = 0; k < 10; k++) begin
            mem[4 + 2*k] = 8'hAB;
            mem[5 + 2*k] = 8'hCD;
        end
        for (int k = 0; k < 8; k++) rd_q.push_back(rd(4'd2, 32'(4 + 2*k)));
        run_pkt("loop_guard", 1'b0, 32'h99, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
